instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Upstream neighbour of control_unit. Owns the PC and issues one outstanding request at a time to instruction memory.
- Holds each returned instruction in an instruction register and presents opcode/funct3/funct7 slices to control_unit.
- Accepts branch/jump redirects, which are driven by PCSrc and the computed target.
- Handshakes with downstream using valid/ready, discards stale memory responses after a redirect, and flags misaligned targets and memory timeouts.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- TIMEOUT_CYCLES, 16, maximum cycles spent in WAIT or DRAIN without imem_rvalid before fetch_error is raised.
- NOP_INSTR, 32'h0000_0013, value driven on instr when no valid instruction is held.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  one-cycle request pulse.
- imem_addr  out  32  fetch address; valid when imem_req=1.
- imem_rdata  in  32  instruction word; valid when imem_rvalid=1.
- imem_rvalid  in  1  response strobe; arrives at least 1 cycle after imem_req.
- redirect  in  1  PCSrc from control_unit; single-cycle pulse.
- redirect_target  in  32  branch/JAL target.
- instr_ready  in  1  downstream consumes the instruction at the clock edge when instr_valid=1.
- instr_valid  out  1  instr/pc are valid.
- instr  out  32  instruction register.
- pc  out  32  address of instr.
- pc_plus4  out  32  pc+4, modulo 2^32.
- opcode  out  7  instr[6:0].
- funct3  out  3  instr[14:12].
- funct7  out  7  instr[31:25].
- misaligned  out  1  sticky; set when a redirect target has [1:0]!=0.
- fetch_error  out  1  sticky; set on timeout.

Behaviour:
- Clock and reset: one clock (clk); synchronous active-high reset (rst).
- Values while rst=1 (and for the cycle after release):
  - state=FETCH, fetch_pc=RESET_PC
  - imem_req=0, instr_valid=0, instr=NOP_INSTR, pc=RESET_PC
  - misaligned=0, fetch_error=0, timeout counter=0
- Reset mid-operation: any in-flight response is ignored. An imem_rvalid arriving in FETCH is also ignored.
- States: FETCH, WAIT, VALID, DRAIN, HALT.
- FETCH:
  - Drive imem_req=1 and imem_addr=fetch_pc for exactly one cycle, then go to WAIT.
  - A redirect in this cycle captures the target and goes to DRAIN, because the issued request is now stale.
- WAIT:
  - On imem_rvalid: instr<=imem_rdata, pc<=fetch_pc, go to VALID.
  - On redirect: capture the target and go to DRAIN. If imem_rvalid is in the same cycle, the response is discarded and the next state is FETCH at the target.
- VALID:
  - instr_valid=1; instr/pc stay stable until consumed.
  - instr_ready=1, no redirect: fetch_pc<=pc+4, go to FETCH.
  - redirect=1 (with or without ready): fetch_pc<=redirect_target, go to FETCH. Redirect wins over sequential increment.
  - On leaving VALID, instr_valid drops and instr returns to NOP_INSTR.
- DRAIN:
  - imem_req=0. Wait for imem_rvalid, discard the data, then go to FETCH with fetch_pc=captured target.
  - A further redirect overwrites the captured target; the last one wins.
- Misaligned target: checked when a redirect is accepted. If redirect_target[1:0]!=0, set misaligned=1 and go to HALT. No further imem_req is issued; misaligned alone clears instr_valid, and HALT remains until rst.
- Timeout:
  - The counter increments every cycle in WAIT or DRAIN and clears on leaving those states.
  - Reaching TIMEOUT_CYCLES sets fetch_error=1 and goes to HALT.
- HALT: imem_req=0 and instr_valid=0; exited only by rst.
- Arithmetic: pc+4 wraps modulo 2^32, so 32'hFFFF_FFFC → 32'h0000_0000.
- Latency: imem_req in cycle N, imem_rvalid in N+k (k≥1), instr_valid in N+k+1. With k=1 and instr_ready held at 1, there is one instruction every 3 cycles.
- Outputs opcode/funct3/funct7/pc_plus4 are combinational slices of the registered instr/pc.

Test Plan:
- Reset/sequential fetch: rst for 2 cycles, 1-cycle memory returning 0x00500093 @0, 0x00000013 @4, ready=1 → first imem_req one cycle after release with addr 0x0; instr_valid with pc=0, opcode=0010011, funct3=000; next request at addr 0x4, pc_plus4=0x8.
- Backpressure: instr_ready=0 for 5 cycles in VALID → instr/pc stable, no imem_req; ready=1 → fetch at pc+4 the following cycle.
- Redirect in VALID: pc=0x10, redirect=1, target=0x40, ready=1 → next imem_addr=0x40, not 0x14.
- Redirect in WAIT with 3-cycle memory: stale rdata 0xDEADBEEF is discarded (instr_valid never 1 with it); next request at target 0x100; instr at pc=0x100 delivered.
- Misaligned/timeout:
  - redirect_target=0x42 → misaligned=1, HALT, no imem_req until rst.
  - Separately, memory never responds → fetch_error=1 after 16 cycles in WAIT; rst clears both flags.
- Wrap: RESET_PC=0xFFFFFFFC, ready=1 → second request addr 0x00000000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, keeps one imem request in flight, hands instr/pc downstream via valid/ready.
// Latency: request cycle N, response N+k, instr_valid N+k+1; while instr_ready=0 the instruction is held and no fetch issues.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic        misaligned,
  output logic        fetch_error
);

  typedef enum logic [2:0] {FETCH, WAIT, VALID, DRAIN, HALT} state_t;

  localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] tcnt;
  logic          bad_target;
  logic          waiting;
  logic          timed_out;
  logic          restart;
  logic [31:0]   restart_pc;

  assign bad_target = redirect && (redirect_target[1:0] != 2'b00) && (state != HALT);
  assign waiting    = (state == WAIT) || (state == DRAIN);
  assign timed_out  = waiting && !imem_rvalid && (tcnt == TO_LAST);

  // Transitions that launch a new request immediately, so FETCH spends one cycle per fetch.
  always_comb begin
    restart    = 1'b0;
    restart_pc = fetch_pc;
    case (state)
      WAIT: begin
        if (redirect && imem_rvalid) begin
          restart    = 1'b1;
          restart_pc = redirect_target;
        end
      end
      VALID: begin
        if (redirect) begin
          restart    = 1'b1;
          restart_pc = redirect_target;
        end else if (instr_ready) begin
          restart    = 1'b1;
          restart_pc = pc_plus4;
        end
      end
      DRAIN: begin
        if (imem_rvalid) begin
          restart    = 1'b1;
          restart_pc = redirect ? redirect_target : fetch_pc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      tcnt        <= '0;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
      pc          <= RESET_PC;
      misaligned  <= 1'b0;
      fetch_error <= 1'b0;
    end else if (bad_target || timed_out) begin
      state       <= HALT;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
      tcnt        <= '0;
      if (bad_target) misaligned <= 1'b1;
      else            fetch_error <= 1'b1;
    end else if (restart) begin
      state       <= FETCH;
      fetch_pc    <= restart_pc;
      imem_req    <= 1'b1;
      imem_addr   <= restart_pc;
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
      tcnt        <= '0;
    end else begin
      case (state)
        FETCH: begin
          // Only the first cycle out of reset arrives here with no request launched yet.
          if (!imem_req) begin
            imem_req  <= 1'b1;
            imem_addr <= redirect ? redirect_target : fetch_pc;
            if (redirect) fetch_pc <= redirect_target;
          end else begin
            imem_req <= 1'b0;
            if (redirect) begin
              fetch_pc <= redirect_target;
              state    <= DRAIN;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (redirect) begin
            fetch_pc <= redirect_target;
            state    <= DRAIN;
            tcnt     <= tcnt + 1'b1;
          end else if (imem_rvalid) begin
            instr       <= imem_rdata;
            pc          <= fetch_pc;
            instr_valid <= 1'b1;
            state       <= VALID;
            tcnt        <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DRAIN: begin
          tcnt <= tcnt + 1'b1;
          if (redirect) fetch_pc <= redirect_target;
        end
        default: ;
      endcase
    end
  end

  assign pc_plus4 = pc + 32'd4;
  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: tests queue expected requests/deliveries, monitors pop and compare.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        misaligned;
  logic        fetch_error;

  logic        rst_w;
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic        w_rvalid;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [31:0] w_pc4;
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic        w_mis;
  logic        w_err;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] pc4;
  } exp_t;

  logic [31:0] req_q[$];
  exp_t        del_q[$];
  logic [31:0] wreq_q[$];

  int          n_chk = 0;
  int          n_fail = 0;
  int          mem_lat = 1;
  bit          mem_en = 1'b1;
  logic [31:0] poison_addr = 32'hFFFF_FFF0;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
    .redirect(redirect), .redirect_target(redirect_target), .instr_ready(instr_ready),
    .instr_valid(instr_valid), .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .misaligned(misaligned), .fetch_error(fetch_error)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst_w),
    .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata), .imem_rvalid(w_rvalid),
    .redirect(1'b0), .redirect_target(32'h0), .instr_ready(1'b1),
    .instr_valid(w_valid), .instr(w_instr), .pc(w_pc), .pc_plus4(w_pc4),
    .opcode(w_opcode), .funct3(w_funct3), .funct7(w_funct7),
    .misaligned(w_mis), .fetch_error(w_err)
  );

  assign w_rdata = NOP;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h0000_0013;
      default: return {a[23:0], 8'h13};
    endcase
  endfunction

  task automatic push_del(input logic [31:0] p, input logic [31:0] ins, input logic [31:0] p4);
    exp_t e;
    e.pc = p; e.ins = ins; e.pc4 = p4;
    del_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", pc, 32'h0);
    chk("rst_misaligned", misaligned, 0);
    chk("rst_fetch_error", fetch_error, 0);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 60; i++) begin
      step();
      if (instr_valid) return;
    end
    n_chk++; n_fail++;
    $display("FAIL %s_wait_valid: instr_valid not seen within 60 cycles", name);
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 60; i++) begin
      step();
      if (imem_req) return;
    end
    n_chk++; n_fail++;
    $display("FAIL %s_wait_req: imem_req not seen within 60 cycles", name);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 80; i++) begin
      if (req_q.size() == 0 && del_q.size() == 0) break;
      step();
    end
    chk({name, "_req_left"}, 32'(req_q.size()), 0);
    chk({name, "_del_left"}, 32'(del_q.size()), 0);
  endtask

  initial begin : mem_model
    logic [31:0] a;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (imem_req && mem_en && !rst) begin
        a = imem_addr;
        repeat (mem_lat) @(posedge clk);
        #1;
        imem_rvalid = 1'b1;
        imem_rdata  = (a == poison_addr) ? 32'hDEAD_BEEF : mem_word(a);
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
      end
    end
  end

  initial begin : wrap_mem
    w_rvalid = 1'b0;
    forever begin
      @(negedge clk);
      if (w_req && !rst_w) begin
        @(posedge clk); #1; w_rvalid = 1'b1;
        @(posedge clk); #1; w_rvalid = 1'b0;
      end
    end
  end

  initial begin : monitor
    exp_t        e;
    logic [31:0] ea;
    forever begin
      @(negedge clk);
      if (!rst && imem_req) begin
        chk("req_expected", 32'(req_q.size() != 0), 1);
        if (req_q.size() != 0) chk("req_addr", imem_addr, req_q.pop_front());
      end
      if (!rst && instr_valid && instr_ready) begin
        chk("del_expected", 32'(del_q.size() != 0), 1);
        if (del_q.size() != 0) begin
          e  = del_q.pop_front();
          ea = e.ins;
          chk("del_pc", pc, e.pc);
          chk("del_instr", instr, e.ins);
          chk("del_pc_plus4", pc_plus4, e.pc4);
          chk("del_opcode", opcode, ea[6:0]);
          chk("del_funct3", funct3, ea[14:12]);
          chk("del_funct7", funct7, ea[31:25]);
        end
      end
      if (!rst_w && w_req) begin
        chk("wrap_req_expected", 32'(wreq_q.size() != 0), 1);
        if (wreq_q.size() != 0) chk("wrap_req_addr", w_addr, wreq_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #60000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst = 1'b1; rst_w = 1'b1;
    redirect = 1'b0; redirect_target = '0; instr_ready = 1'b1;

    // Sequential fetch with 1-cycle memory.
    req_q.push_back(32'h0); req_q.push_back(32'h4);
    push_del(32'h0, 32'h0050_0093, 32'h4);
    push_del(32'h4, 32'h0000_0013, 32'h8);
    do_reset();
    step();
    chk("t1_first_req", imem_req, 1);
    chk("t1_first_addr", imem_addr, 32'h0);
    wait_valid("t1");
    chk("t1_opcode", opcode, 7'b0010011);
    chk("t1_funct3", funct3, 3'b000);
    chk("t1_pc", pc, 32'h0);
    wait_drain("t1");

    // Backpressure: instruction held for 5 cycles, then sequential fetch.
    instr_ready = 1'b0;
    req_q.push_back(32'h0); req_q.push_back(32'h4);
    push_del(32'h0, 32'h0050_0093, 32'h4);
    push_del(32'h4, 32'h0000_0013, 32'h8);
    do_reset();
    wait_valid("t2");
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_instr", instr, 32'h0050_0093);
      chk("t2_hold_pc", pc, 32'h0);
      chk("t2_no_req", imem_req, 0);
      step();
    end
    instr_ready = 1'b1;
    step();
    chk("t2_next_req", imem_req, 1);
    chk("t2_next_addr", imem_addr, 32'h4);
    wait_drain("t2");

    // Redirect while pc=0x10 is presented.
    req_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h40};
    push_del(32'h0,  32'h0050_0093, 32'h4);
    push_del(32'h4,  32'h0000_0013, 32'h8);
    push_del(32'h8,  32'h0000_0813, 32'hC);
    push_del(32'hC,  32'h0000_0C13, 32'h10);
    push_del(32'h10, 32'h0000_1013, 32'h14);
    push_del(32'h40, 32'h0000_4013, 32'h44);
    do_reset();
    for (int i = 0; i < 60; i++) begin
      step();
      if (instr_valid && pc == 32'h10) break;
    end
    chk("t3_at_pc10", pc, 32'h10);
    redirect = 1'b1; redirect_target = 32'h40;
    step();
    redirect = 1'b0;
    chk("t3_redirect_req", imem_req, 1);
    chk("t3_redirect_addr", imem_addr, 32'h40);
    wait_drain("t3");

    // Redirect in WAIT with 3-cycle memory; stale data must be dropped.
    mem_lat = 3; poison_addr = 32'h0;
    req_q.push_back(32'h0); req_q.push_back(32'h100);
    push_del(32'h100, 32'h0001_0013, 32'h104);
    do_reset();
    wait_req("t4");
    step();
    redirect = 1'b1; redirect_target = 32'h100;
    step();
    redirect = 1'b0;
    chk("t4_drain_no_valid", instr_valid, 0);
    wait_drain("t4");
    mem_lat = 1; poison_addr = 32'hFFFF_FFF0;

    // Misaligned redirect halts the unit.
    req_q.push_back(32'h0);
    push_del(32'h0, 32'h0050_0093, 32'h4);
    do_reset();
    wait_valid("t5");
    redirect = 1'b1; redirect_target = 32'h42;
    step();
    redirect = 1'b0;
    chk("t5_misaligned", misaligned, 1);
    chk("t5_valid_low", instr_valid, 0);
    chk("t5_instr_nop", instr, NOP);
    repeat (10) step();
    chk("t5_still_misaligned", misaligned, 1);
    chk("t5_halt_no_req", imem_req, 0);
    chk("t5_no_fetch_error", fetch_error, 0);
    wait_drain("t5");

    // Memory never answers: timeout after 16 WAIT cycles.
    mem_en = 1'b0;
    req_q.push_back(32'h0);
    do_reset();
    wait_req("t6");
    repeat (16) step();
    chk("t6_err_not_yet", fetch_error, 0);
    step();
    chk("t6_fetch_error", fetch_error, 1);
    chk("t6_valid_low", instr_valid, 0);
    repeat (5) step();
    chk("t6_halt_no_req", imem_req, 0);
    wait_drain("t6");
    rst = 1'b1;
    repeat (2) step();
    chk("t6_rst_clears_err", fetch_error, 0);
    chk("t6_rst_clears_mis", misaligned, 0);
    mem_en = 1'b1;

    // PC wrap from 0xFFFFFFFC.
    wreq_q.push_back(32'hFFFF_FFFC); wreq_q.push_back(32'h0);
    rst_w = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (w_valid) break;
    end
    chk("t7_wrap_pc", w_pc, 32'hFFFF_FFFC);
    chk("t7_wrap_pc_plus4", w_pc4, 32'h0);
    chk("t7_wrap_instr", w_instr, NOP);
    chk("t7_wrap_opcode", w_opcode, 7'h13);
    chk("t7_wrap_funct3", w_funct3, 3'h0);
    chk("t7_wrap_funct7", w_funct7, 7'h0);
    chk("t7_wrap_flags", {w_mis, w_err}, 2'b00);
    for (int i = 0; i < 40; i++) begin
      if (wreq_q.size() == 0) break;
      step();
    end
    rst_w = 1'b1;
    chk("t7_wrap_req_left", 32'(wreq_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
